// File: rtl/cdb_arbiter_if.sv
// Result-bus bundle between the two result producers (ALU, LSB), the ROB write
// port and the common data bus arbiter.
interface cdb_arbiter_if #(
    parameter int ROB_WIDTH = 4
);
    logic                 alu_valid;
    logic [ROB_WIDTH-1:0] alu_tag;
    logic [31:0]          alu_wdata;
    logic                 alu_ready;

    logic                 lsb_valid;
    logic [ROB_WIDTH-1:0] lsb_tag;
    logic [31:0]          lsb_wdata;
    logic                 lsb_ready;

    logic                 rob_ready;
    logic                 to_rob;
    logic [ROB_WIDTH-1:0] to_rob_tag;
    logic [31:0]          to_rob_wdata;
    logic                 to_rob_src;

    // Producers and the ROB side.
    modport master (
        output alu_valid, alu_tag, alu_wdata,
        output lsb_valid, lsb_tag, lsb_wdata,
        output rob_ready,
        input  alu_ready, lsb_ready,
        input  to_rob, to_rob_tag, to_rob_wdata, to_rob_src
    );

    // Arbiter side.
    modport slave (
        input  alu_valid, alu_tag, alu_wdata,
        input  lsb_valid, lsb_tag, lsb_wdata,
        input  rob_ready,
        output alu_ready, lsb_ready,
        output to_rob, to_rob_tag, to_rob_wdata, to_rob_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: queues ALU and LSB results in small circular FIFOs
// and writes them one per cycle to the ROB, alternating source under contention.
//
// prio state | meaning
// PRIO_ALU   | ALU wins if both queues hold a result (reset / flush value)
// PRIO_LSB   | LSB wins if both queues hold a result
module cdb_arbiter #(
    parameter int ROB_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         rdy_in,
    input  logic         clear,
    cdb_arbiter_if.slave bus
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_LSB = 1'b1
    } prio_e;

    logic [ROB_WIDTH-1:0] alu_tag_mem  [FIFO_DEPTH];
    logic [31:0]          alu_data_mem [FIFO_DEPTH];
    logic [ROB_WIDTH-1:0] lsb_tag_mem  [FIFO_DEPTH];
    logic [31:0]          lsb_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] alu_head_q, alu_head_d;
    logic [PTR_W-1:0] alu_tail_q, alu_tail_d;
    logic [CNT_W-1:0] alu_cnt_q,  alu_cnt_d;
    logic [PTR_W-1:0] lsb_head_q, lsb_head_d;
    logic [PTR_W-1:0] lsb_tail_q, lsb_tail_d;
    logic [CNT_W-1:0] lsb_cnt_q,  lsb_cnt_d;

    prio_e                prio_q, prio_d;
    logic                 to_rob_q, to_rob_d;
    logic                 src_q, src_d;
    logic [ROB_WIDTH-1:0] tag_q, tag_d;
    logic [31:0]          wdata_q, wdata_d;

    logic enable;
    logic alu_ready, lsb_ready;
    logic alu_nonempty, lsb_nonempty;
    logic alu_push, lsb_push;
    logic step;
    logic grant_alu, grant_lsb;

    // Ready looks only at registered counts so a producer never sees a
    // combinational path from the ROB side.
    assign alu_ready    = (alu_cnt_q < DEPTH_C);
    assign lsb_ready    = (lsb_cnt_q < DEPTH_C);
    assign alu_nonempty = (alu_cnt_q != '0);
    assign lsb_nonempty = (lsb_cnt_q != '0);

    assign enable   = rdy_in & ~clear;
    assign alu_push = enable & bus.alu_valid & alu_ready;
    assign lsb_push = enable & bus.lsb_valid & lsb_ready;
    assign step     = enable & bus.rob_ready;

    assign grant_alu = step & alu_nonempty & (~lsb_nonempty | (prio_q == PRIO_ALU));
    assign grant_lsb = step & lsb_nonempty & (~alu_nonempty | (prio_q == PRIO_LSB));

    assign bus.alu_ready    = alu_ready;
    assign bus.lsb_ready    = lsb_ready;
    assign bus.to_rob       = to_rob_q;
    assign bus.to_rob_tag   = tag_q;
    assign bus.to_rob_wdata = wdata_q;
    assign bus.to_rob_src   = src_q;

    // Queue storage carries no reset; validity is tracked by the counts.
    always_ff @(posedge clk_in) begin
        if (alu_push) begin
            alu_tag_mem[alu_tail_q]  <= bus.alu_tag;
            alu_data_mem[alu_tail_q] <= bus.alu_wdata;
        end
        if (lsb_push) begin
            lsb_tag_mem[lsb_tail_q]  <= bus.lsb_tag;
            lsb_data_mem[lsb_tail_q] <= bus.lsb_wdata;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            alu_head_q <= '0;
            alu_tail_q <= '0;
            alu_cnt_q  <= '0;
            lsb_head_q <= '0;
            lsb_tail_q <= '0;
            lsb_cnt_q  <= '0;
            prio_q     <= PRIO_ALU;
            to_rob_q   <= 1'b0;
            src_q      <= 1'b0;
            tag_q      <= '0;
            wdata_q    <= '0;
        end else begin
            alu_head_q <= alu_head_d;
            alu_tail_q <= alu_tail_d;
            alu_cnt_q  <= alu_cnt_d;
            lsb_head_q <= lsb_head_d;
            lsb_tail_q <= lsb_tail_d;
            lsb_cnt_q  <= lsb_cnt_d;
            prio_q     <= prio_d;
            to_rob_q   <= to_rob_d;
            src_q      <= src_d;
            tag_q      <= tag_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        alu_head_d = alu_head_q;
        alu_tail_d = alu_tail_q;
        alu_cnt_d  = alu_cnt_q;
        lsb_head_d = lsb_head_q;
        lsb_tail_d = lsb_tail_q;
        lsb_cnt_d  = lsb_cnt_q;
        prio_d     = prio_q;
        to_rob_d   = to_rob_q;
        src_d      = src_q;
        tag_d      = tag_q;
        wdata_d    = wdata_q;

        if (rdy_in) begin
            if (clear) begin
                // Flush wins over push and grant; data outputs keep their value.
                alu_head_d = '0;
                alu_tail_d = '0;
                alu_cnt_d  = '0;
                lsb_head_d = '0;
                lsb_tail_d = '0;
                lsb_cnt_d  = '0;
                prio_d     = PRIO_ALU;
                to_rob_d   = 1'b0;
            end else begin
                to_rob_d = grant_alu | grant_lsb;

                if (alu_push)  alu_tail_d = alu_tail_q + PTR_ONE;
                if (grant_alu) alu_head_d = alu_head_q + PTR_ONE;
                alu_cnt_d = alu_cnt_q + CNT_W'(alu_push) - CNT_W'(grant_alu);

                if (lsb_push)  lsb_tail_d = lsb_tail_q + PTR_ONE;
                if (grant_lsb) lsb_head_d = lsb_head_q + PTR_ONE;
                lsb_cnt_d = lsb_cnt_q + CNT_W'(lsb_push) - CNT_W'(grant_lsb);

                if (grant_alu) begin
                    tag_d   = alu_tag_mem[alu_head_q];
                    wdata_d = alu_data_mem[alu_head_q];
                    src_d   = 1'b0;
                    prio_d  = PRIO_LSB;
                end else if (grant_lsb) begin
                    tag_d   = lsb_tag_mem[lsb_head_q];
                    wdata_d = lsb_data_mem[lsb_head_q];
                    src_d   = 1'b1;
                    prio_d  = PRIO_ALU;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single write, contention, backpressure,
// flush, stall and mid-burst reset, each with hand-computed expectations.
module tb_cdb_arbiter;

    logic clk_in   = 1'b0;
    logic rst_n_in = 1'b0;
    logic rdy_in   = 1'b1;
    logic clear    = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    cdb_arbiter_if #(.ROB_WIDTH(4)) bus ();

    cdb_arbiter #(.ROB_WIDTH(4), .FIFO_DEPTH(2)) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .clear    (clear),
        .bus      (bus)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_alu(input logic v, input logic [3:0] t, input logic [31:0] d);
        bus.alu_valid = v;
        bus.alu_tag   = t;
        bus.alu_wdata = d;
    endtask

    task automatic set_lsb(input logic v, input logic [3:0] t, input logic [31:0] d);
        bus.lsb_valid = v;
        bus.lsb_tag   = t;
        bus.lsb_wdata = d;
    endtask

    task automatic expect_wr(input string tag, input logic [3:0] t, input logic s, input logic [31:0] d);
        check_val({tag, ".to_rob"}, 32'(bus.to_rob), 32'd1);
        check_val({tag, ".tag"},    32'(bus.to_rob_tag), 32'(t));
        check_val({tag, ".src"},    32'(bus.to_rob_src), 32'(s));
        check_val({tag, ".wdata"},  bus.to_rob_wdata, d);
    endtask

    task automatic do_reset();
        set_alu(1'b0, 4'h0, 32'h0);
        set_lsb(1'b0, 4'h0, 32'h0);
        bus.rob_ready = 1'b0;
        rdy_in = 1'b1;
        clear  = 1'b0;
        rst_n_in = 1'b0;
        #2;
        rst_n_in = 1'b1;
        tick();
    endtask

    initial begin
        set_alu(1'b0, 4'h0, 32'h0);
        set_lsb(1'b0, 4'h0, 32'h0);
        bus.rob_ready = 1'b0;

        // Reset values
        #12;
        check_val("rst.to_rob",    32'(bus.to_rob), 32'd0);
        check_val("rst.tag",       32'(bus.to_rob_tag), 32'd0);
        check_val("rst.wdata",     bus.to_rob_wdata, 32'd0);
        check_val("rst.src",       32'(bus.to_rob_src), 32'd0);
        check_val("rst.alu_ready", 32'(bus.alu_ready), 32'd1);
        check_val("rst.lsb_ready", 32'(bus.lsb_ready), 32'd1);
        rst_n_in = 1'b1;
        tick();

        // Single ALU result: pushed at edge N, written after edge N+1
        set_alu(1'b1, 4'd3, 32'h55);
        bus.rob_ready = 1'b1;
        tick();
        set_alu(1'b0, 4'd0, 32'h0);
        check_val("single.latency", 32'(bus.to_rob), 32'd0);
        tick();
        expect_wr("single", 4'd3, 1'b0, 32'h55);
        tick();
        check_val("single.drop", 32'(bus.to_rob), 32'd0);
        check_val("single.hold", bus.to_rob_wdata, 32'h55);

        // Contention: order 1(ALU), 5(LSB), 2(ALU), 6(LSB)
        do_reset();
        bus.rob_ready = 1'b1;
        set_alu(1'b1, 4'd1, 32'h101);
        set_lsb(1'b1, 4'd5, 32'h505);
        tick();
        set_alu(1'b1, 4'd2, 32'h202);
        set_lsb(1'b1, 4'd6, 32'h606);
        check_val("cont.idle", 32'(bus.to_rob), 32'd0);
        tick();
        set_alu(1'b0, 4'd0, 32'h0);
        set_lsb(1'b0, 4'd0, 32'h0);
        expect_wr("cont.w0", 4'd1, 1'b0, 32'h101);
        tick();
        expect_wr("cont.w1", 4'd5, 1'b1, 32'h505);
        tick();
        expect_wr("cont.w2", 4'd2, 1'b0, 32'h202);
        tick();
        expect_wr("cont.w3", 4'd6, 1'b1, 32'h606);
        tick();
        check_val("cont.done", 32'(bus.to_rob), 32'd0);

        // Backpressure: third ALU push held until the ROB drains
        do_reset();
        bus.rob_ready = 1'b0;
        set_alu(1'b1, 4'd7, 32'h77);
        tick();
        check_val("bp.ready1", 32'(bus.alu_ready), 32'd1);
        set_alu(1'b1, 4'd8, 32'h88);
        tick();
        check_val("bp.full", 32'(bus.alu_ready), 32'd0);
        set_alu(1'b1, 4'd9, 32'h99);
        tick();
        check_val("bp.held", 32'(bus.alu_ready), 32'd0);
        check_val("bp.nowr", 32'(bus.to_rob), 32'd0);
        bus.rob_ready = 1'b1;
        tick();
        expect_wr("bp.w0", 4'd7, 1'b0, 32'h77);
        check_val("bp.ready2", 32'(bus.alu_ready), 32'd1);
        tick();
        set_alu(1'b0, 4'd0, 32'h0);
        expect_wr("bp.w1", 4'd8, 1'b0, 32'h88);
        tick();
        expect_wr("bp.w2", 4'd9, 1'b0, 32'h99);
        tick();
        check_val("bp.nodup", 32'(bus.to_rob), 32'd0);

        // Flush with both queues full and prio pointing at LSB
        do_reset();
        bus.rob_ready = 1'b1;
        set_alu(1'b1, 4'd1, 32'h11);
        tick();
        set_alu(1'b0, 4'd0, 32'h0);
        tick();
        expect_wr("fl.pre", 4'd1, 1'b0, 32'h11);
        bus.rob_ready = 1'b0;
        set_alu(1'b1, 4'd2, 32'h22);
        set_lsb(1'b1, 4'd3, 32'h33);
        tick();
        set_alu(1'b1, 4'd4, 32'h44);
        set_lsb(1'b1, 4'd5, 32'h55);
        tick();
        check_val("fl.alu_full", 32'(bus.alu_ready), 32'd0);
        check_val("fl.lsb_full", 32'(bus.lsb_ready), 32'd0);
        clear = 1'b1;
        bus.rob_ready = 1'b1;
        set_alu(1'b1, 4'hE, 32'hEE);
        set_lsb(1'b0, 4'd0, 32'h0);
        tick();
        clear = 1'b0;
        set_alu(1'b0, 4'd0, 32'h0);
        check_val("fl.to_rob", 32'(bus.to_rob), 32'd0);
        check_val("fl.alu_rdy", 32'(bus.alu_ready), 32'd1);
        check_val("fl.lsb_rdy", 32'(bus.lsb_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("fl.stale%0d", i), 32'(bus.to_rob), 32'd0);
        end
        set_alu(1'b1, 4'hA, 32'hAA);
        set_lsb(1'b1, 4'hB, 32'hBB);
        tick();
        set_alu(1'b0, 4'd0, 32'h0);
        set_lsb(1'b0, 4'd0, 32'h0);
        tick();
        expect_wr("fl.first", 4'hA, 1'b0, 32'hAA);
        tick();
        expect_wr("fl.second", 4'hB, 1'b1, 32'hBB);

        // Stall: rdy_in=0 freezes everything, even with clear and valid active
        do_reset();
        bus.rob_ready = 1'b1;
        set_alu(1'b1, 4'd4, 32'h44);
        set_lsb(1'b1, 4'd6, 32'h66);
        tick();
        set_alu(1'b0, 4'd0, 32'h0);
        set_lsb(1'b0, 4'd0, 32'h0);
        tick();
        expect_wr("st.w0", 4'd4, 1'b0, 32'h44);
        rdy_in = 1'b0;
        clear  = 1'b1;
        set_alu(1'b1, 4'hF, 32'hFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_wr($sformatf("st.frz%0d", i), 4'd4, 1'b0, 32'h44);
        end
        rdy_in = 1'b1;
        clear  = 1'b0;
        set_alu(1'b0, 4'd0, 32'h0);
        tick();
        expect_wr("st.w1", 4'd6, 1'b1, 32'h66);

        // Reset mid-burst: outputs drop at once, queued results are lost
        set_alu(1'b1, 4'd1, 32'h10);
        set_lsb(1'b1, 4'd2, 32'h20);
        tick();
        set_alu(1'b1, 4'd3, 32'h30);
        set_lsb(1'b0, 4'd0, 32'h0);
        tick();
        set_alu(1'b0, 4'd0, 32'h0);
        expect_wr("rb.w0", 4'd1, 1'b0, 32'h10);
        #2;
        rst_n_in = 1'b0;
        #1;
        check_val("rb.to_rob", 32'(bus.to_rob), 32'd0);
        check_val("rb.tag",    32'(bus.to_rob_tag), 32'd0);
        check_val("rb.wdata",  bus.to_rob_wdata, 32'd0);
        check_val("rb.src",    32'(bus.to_rob_src), 32'd0);
        tick();
        rst_n_in = 1'b1;
        check_val("rb.alu_rdy", 32'(bus.alu_ready), 32'd1);
        check_val("rb.lsb_rdy", 32'(bus.lsb_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val($sformatf("rb.empty%0d", i), 32'(bus.to_rob), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
